// File: rtl/axi_lite_arb_pkg.sv
// Shared types and constants for the 2:1 AXI4-Lite arbiter.
package axi_lite_arb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR_AD = 3'd1,
    WR_B  = 3'd2,
    RD_A  = 3'd3,
    RD_R  = 3'd4
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_lite_arb_sel.sv
// Picks the winning master and its operation from the raw request bits.
// Latency: purely combinational, no state.
// Backpressure: none; the caller only samples the result while idle.
module axi_lite_arb_sel
  import axi_lite_arb_pkg::*;
(
  input  logic [1:0] wr_req,
  input  logic [1:0] rd_req,
  input  logic       rr_ptr,
  input  op_t        last_op [2],
  output logic       win,
  output op_t        op,
  output logic       vld
);

  logic [1:0] any_req;
  logic       w;
  logic       r;

  always_comb begin
    any_req = wr_req | rd_req;
    vld     = |any_req;
    win     = (any_req == 2'b11) ? rr_ptr : any_req[1];
    w       = wr_req[win];
    r       = rd_req[win];
    op      = OP_RD;
    // With both pending, take the opposite of what this master did last time.
    if (w && r) begin
      op = (last_op[win] == OP_RD) ? OP_WR : OP_RD;
    end else if (w) begin
      op = OP_WR;
    end
  end

endmodule

// File: rtl/axi_lite_arb_2to1.sv
// Two-master to one-slave AXI4-Lite arbiter, one transaction in flight, round-robin masters.
// Latency: 1 cycle grant in IDLE, then combinational forwarding through the registered-grant mux.
// Backpressure: slave READY/VALID pass straight to the owner; the non-owner sees all handshakes held at 0.
module axi_lite_arb_2to1
  import axi_lite_arb_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic                ACLK,
  input  logic                ARESET,

  input  logic [ADDR_W-1:0]   M0_AWADDR,
  input  logic                M0_AWVALID,
  output logic                M0_AWREADY,
  input  logic [DATA_W-1:0]   M0_WDATA,
  input  logic [DATA_W/8-1:0] M0_WSTRB,
  input  logic                M0_WVALID,
  output logic                M0_WREADY,
  output logic [1:0]          M0_BRESP,
  output logic                M0_BVALID,
  input  logic                M0_BREADY,
  input  logic [ADDR_W-1:0]   M0_ARADDR,
  input  logic                M0_ARVALID,
  output logic                M0_ARREADY,
  output logic [DATA_W-1:0]   M0_RDATA,
  output logic [1:0]          M0_RRESP,
  output logic                M0_RVALID,
  input  logic                M0_RREADY,

  input  logic [ADDR_W-1:0]   M1_AWADDR,
  input  logic                M1_AWVALID,
  output logic                M1_AWREADY,
  input  logic [DATA_W-1:0]   M1_WDATA,
  input  logic [DATA_W/8-1:0] M1_WSTRB,
  input  logic                M1_WVALID,
  output logic                M1_WREADY,
  output logic [1:0]          M1_BRESP,
  output logic                M1_BVALID,
  input  logic                M1_BREADY,
  input  logic [ADDR_W-1:0]   M1_ARADDR,
  input  logic                M1_ARVALID,
  output logic                M1_ARREADY,
  output logic [DATA_W-1:0]   M1_RDATA,
  output logic [1:0]          M1_RRESP,
  output logic                M1_RVALID,
  input  logic                M1_RREADY,

  output logic [ADDR_W-1:0]   S_AWADDR,
  output logic                S_AWVALID,
  input  logic                S_AWREADY,
  output logic [DATA_W-1:0]   S_WDATA,
  output logic [DATA_W/8-1:0] S_WSTRB,
  output logic                S_WVALID,
  input  logic                S_WREADY,
  input  logic [1:0]          S_BRESP,
  input  logic                S_BVALID,
  output logic                S_BREADY,
  output logic [ADDR_W-1:0]   S_ARADDR,
  output logic                S_ARVALID,
  input  logic                S_ARREADY,
  input  logic [DATA_W-1:0]   S_RDATA,
  input  logic [1:0]          S_RRESP,
  input  logic                S_RVALID,
  output logic                S_RREADY,

  output logic [1:0]          GNT
);

  state_t state, state_nxt;
  logic   owner, owner_nxt;
  logic   rr_ptr, rr_ptr_nxt;
  op_t    last_op [2];
  op_t    last_op_nxt [2];
  logic   aw_done, aw_done_nxt;
  logic   w_done, w_done_nxt;

  logic   sel_win;
  logic   sel_vld;
  op_t    sel_op;

  axi_lite_arb_sel u_sel (
    .wr_req  ({M1_AWVALID, M0_AWVALID}),
    .rd_req  ({M1_ARVALID, M0_ARVALID}),
    .rr_ptr  (rr_ptr),
    .last_op (last_op),
    .win     (sel_win),
    .op      (sel_op),
    .vld     (sel_vld)
  );

  // Owner-side request mux; payloads follow the owner even when not forwarded.
  logic o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready;

  assign o_awvalid = owner ? M1_AWVALID : M0_AWVALID;
  assign o_wvalid  = owner ? M1_WVALID  : M0_WVALID;
  assign o_bready  = owner ? M1_BREADY  : M0_BREADY;
  assign o_arvalid = owner ? M1_ARVALID : M0_ARVALID;
  assign o_rready  = owner ? M1_RREADY  : M0_RREADY;

  assign S_AWADDR  = owner ? M1_AWADDR  : M0_AWADDR;
  assign S_WDATA   = owner ? M1_WDATA   : M0_WDATA;
  assign S_WSTRB   = owner ? M1_WSTRB   : M0_WSTRB;
  assign S_ARADDR  = owner ? M1_ARADDR  : M0_ARADDR;

  logic fwd_aw, fwd_w, fwd_b, fwd_ar, fwd_r;

  // A channel whose handshake already completed stays blocked for the rest of WR_AD.
  assign fwd_aw = (state == WR_AD) && !aw_done;
  assign fwd_w  = (state == WR_AD) && !w_done;
  assign fwd_b  = (state == WR_B);
  assign fwd_ar = (state == RD_A);
  assign fwd_r  = (state == RD_R);

  assign S_AWVALID = fwd_aw && o_awvalid;
  assign S_WVALID  = fwd_w  && o_wvalid;
  assign S_BREADY  = fwd_b  && o_bready;
  assign S_ARVALID = fwd_ar && o_arvalid;
  assign S_RREADY  = fwd_r  && o_rready;

  assign M0_AWREADY = !owner && fwd_aw && S_AWREADY;
  assign M0_WREADY  = !owner && fwd_w  && S_WREADY;
  assign M0_BVALID  = !owner && fwd_b  && S_BVALID;
  assign M0_ARREADY = !owner && fwd_ar && S_ARREADY;
  assign M0_RVALID  = !owner && fwd_r  && S_RVALID;

  assign M1_AWREADY = owner && fwd_aw && S_AWREADY;
  assign M1_WREADY  = owner && fwd_w  && S_WREADY;
  assign M1_BVALID  = owner && fwd_b  && S_BVALID;
  assign M1_ARREADY = owner && fwd_ar && S_ARREADY;
  assign M1_RVALID  = owner && fwd_r  && S_RVALID;

  assign M0_BRESP = S_BRESP;
  assign M0_RRESP = S_RRESP;
  assign M0_RDATA = S_RDATA;
  assign M1_BRESP = S_BRESP;
  assign M1_RRESP = S_RRESP;
  assign M1_RDATA = S_RDATA;

  assign GNT = (state == IDLE) ? 2'b00 : {owner, !owner};

  always_comb begin
    state_nxt   = state;
    owner_nxt   = owner;
    rr_ptr_nxt  = rr_ptr;
    last_op_nxt = last_op;
    aw_done_nxt = aw_done;
    w_done_nxt  = w_done;
    case (state)
      IDLE: begin
        if (sel_vld) begin
          owner_nxt            = sel_win;
          rr_ptr_nxt           = !sel_win;
          last_op_nxt[sel_win] = sel_op;
          state_nxt            = (sel_op == OP_WR) ? WR_AD : RD_A;
        end
      end
      WR_AD: begin
        aw_done_nxt = aw_done || (S_AWVALID && S_AWREADY);
        w_done_nxt  = w_done  || (S_WVALID  && S_WREADY);
        if (aw_done_nxt && w_done_nxt) begin
          state_nxt   = WR_B;
          aw_done_nxt = 1'b0;
          w_done_nxt  = 1'b0;
        end
      end
      WR_B: begin
        if (S_BVALID && S_BREADY) state_nxt = IDLE;
      end
      RD_A: begin
        if (S_ARVALID && S_ARREADY) state_nxt = RD_R;
      end
      RD_R: begin
        if (S_RVALID && S_RREADY) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state      <= IDLE;
      owner      <= 1'b0;
      rr_ptr     <= 1'b0;
      last_op[0] <= OP_RD;
      last_op[1] <= OP_RD;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      rr_ptr     <= rr_ptr_nxt;
      last_op    <= last_op_nxt;
      aw_done    <= aw_done_nxt;
      w_done     <= w_done_nxt;
    end
  end

endmodule
